// File: rtl/apu_length_sequencer_if.sv
// Host-side bundle for the APU frame sequencer / length scheduler.
// master: register-file side (drives strobes and levels, reads status).
// slave : the sequencer (reads strobes and levels, drives status).
//   apu_en    master enable; low holds the sequencer and clears all counters
//   wr_len    per-channel length load strobe (data taken from len_data)
//   len_data  length value; [5:0] for 6-bit channels, [7:0] for the wave channel
//   trig      per-channel trigger strobe
//   len_en    per-channel length-enable level
//   dac_on    per-channel DAC-powered level
//   ch_active per-channel playing flag
//   step      frame-sequencer step 0..7
//   tick_len / tick_sweep / tick_env  one-cycle frame enables
//   busy      decrement walk in progress
interface apu_length_sequencer_if;
    logic       apu_en;
    logic [3:0] wr_len;
    logic [7:0] len_data;
    logic [3:0] trig;
    logic [3:0] len_en;
    logic [3:0] dac_on;
    logic [3:0] ch_active;
    logic [2:0] step;
    logic       tick_len;
    logic       tick_sweep;
    logic       tick_env;
    logic       busy;

    modport master (
        output apu_en, wr_len, len_data, trig, len_en, dac_on,
        input  ch_active, step, tick_len, tick_sweep, tick_env, busy
    );

    modport slave (
        input  apu_en, wr_len, len_data, trig, len_en, dac_on,
        output ch_active, step, tick_len, tick_sweep, tick_env, busy
    );
endinterface

// File: rtl/apu_length_sequencer.sv
// Frame sequencer plus shared length-counter scheduler for a 4-channel APU.
// Ports: clk_i (posedge), rst_i (async, active-high), apu_if (slave bundle).
// A prescaler divides clk_i into 8 frame steps; each wrap yields one-cycle
// tick enables. On tick_len one decrementer walks ch0..ch3, one per cycle.
module apu_length_sequencer #(
    parameter int DIV_512 = 8192,
    parameter int WAVE_CH = 2
) (
    input logic                    clk_i,
    input logic                    rst_i,
    apu_length_sequencer_if.slave  apu_if
);

    localparam int PW = (DIV_512 > 1) ? $clog2(DIV_512) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(DIV_512 - 1);

    typedef enum logic [2:0] {
        IDLE,
        S0,
        S1,
        S2,
        S3
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      step_q, step_d;
    logic            wrap_q, wrap_d;
    logic            tl_q, tl_d;
    logic            ts_q, ts_d;
    logic            te_q, te_d;
    logic [3:0][8:0] rem_q, rem_d;
    logic [3:0]      act_q, act_d;
    logic            slot_vld;
    logic [1:0]      slot_idx;

    // Prescaler and step counter. wrap_q marks the cycle after a wrap,
    // so the ticks are decoded from the step value just entered.
    always_comb begin
        presc_d = presc_q;
        step_d  = step_q;
        wrap_d  = 1'b0;
        tl_d    = 1'b0;
        ts_d    = 1'b0;
        te_d    = 1'b0;
        if (!apu_if.apu_en) begin
            presc_d = '0;
            step_d  = '0;
        end else begin
            if (presc_q == PS_LAST) begin
                presc_d = '0;
                step_d  = step_q + 3'd1;
                wrap_d  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
            if (wrap_q) begin
                tl_d = ~step_q[0];
                ts_d = (step_q[1:0] == 2'd2);
                te_d = (step_q == 3'd7);
            end
        end
    end

    // Scheduler walk: one channel slot per state.
    always_comb begin
        state_d  = state_q;
        slot_vld = 1'b0;
        slot_idx = 2'd0;
        unique case (state_q)
            IDLE: begin
                if (tl_q) state_d = S0;
            end
            S0: begin
                state_d  = S1;
                slot_vld = 1'b1;
                slot_idx = 2'd0;
            end
            S1: begin
                state_d  = S2;
                slot_vld = 1'b1;
                slot_idx = 2'd1;
            end
            S2: begin
                state_d  = S3;
                slot_vld = 1'b1;
                slot_idx = 2'd2;
            end
            S3: begin
                state_d  = IDLE;
                slot_vld = 1'b1;
                slot_idx = 2'd3;
            end
            default: state_d = IDLE;
        endcase
        if (!apu_if.apu_en) state_d = IDLE;
    end

    // Length counters. Host strobes take priority over the walk slot;
    // a trigger sees any same-cycle load, and a dark DAC always wins.
    always_comb begin
        rem_d = rem_q;
        act_d = act_q;
        for (int i = 0; i < 4; i++) begin
            if (apu_if.wr_len[i]) begin
                rem_d[i] = (i == WAVE_CH)
                    ? 9'd256 - {1'b0, apu_if.len_data}
                    : 9'd64 - {3'b000, apu_if.len_data[5:0]};
            end
            if (apu_if.trig[i]) begin
                if (rem_d[i] == '0) begin
                    rem_d[i] = (i == WAVE_CH) ? 9'd256 : 9'd64;
                end
                act_d[i] = apu_if.dac_on[i];
            end
            if (!apu_if.wr_len[i] && !apu_if.trig[i] &&
                slot_vld && slot_idx == 2'(i) &&
                apu_if.len_en[i] && rem_q[i] != '0) begin
                rem_d[i] = rem_q[i] - 9'd1;
                if (rem_q[i] == 9'd1) act_d[i] = 1'b0;
            end
            if (!apu_if.dac_on[i]) act_d[i] = 1'b0;
            if (!apu_if.apu_en) begin
                rem_d[i] = '0;
                act_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            presc_q <= '0;
            step_q  <= '0;
            wrap_q  <= 1'b0;
            tl_q    <= 1'b0;
            ts_q    <= 1'b0;
            te_q    <= 1'b0;
            rem_q   <= '0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            tl_q    <= tl_d;
            ts_q    <= ts_d;
            te_q    <= te_d;
            rem_q   <= rem_d;
            act_q   <= act_d;
        end
    end

    assign apu_if.ch_active  = act_q;
    assign apu_if.step       = step_q;
    assign apu_if.tick_len   = tl_q;
    assign apu_if.tick_sweep = ts_q;
    assign apu_if.tick_env   = te_q;
    assign apu_if.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_apu_length_sequencer.sv
// Scoreboard bench for apu_length_sequencer with DIV_512=16.
// Tick events and walk completions are popped from expectation queues.
module tb_apu_length_sequencer;

    localparam int DIV = 16;

    typedef struct {
        int       cyc;
        logic [2:0] step;
        logic [2:0] flags;
    } tick_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    apu_length_sequencer_if bus ();

    apu_length_sequencer #(
        .DIV_512 (DIV),
        .WAVE_CH (2)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .apu_if (bus)
    );

    tick_t      tick_q[$];
    logic [3:0] walk_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int brun = 0;
    bit mon_ticks = 1'b0;
    bit mon_walks = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: ticks and finished walks pop the scoreboard queues.
    initial forever begin
        @(negedge clk);
        if (mon_ticks &&
            (bus.tick_len || bus.tick_sweep || bus.tick_env)) begin
            if (tick_q.size() == 0) begin
                chk("tick_unexpected", 1, 0);
            end else begin
                chk("tick_cycle", cyc, tick_q[0].cyc);
                chk("tick_step", int'(bus.step), int'(tick_q[0].step));
                chk("tick_flags",
                    int'({bus.tick_len, bus.tick_sweep, bus.tick_env}),
                    int'(tick_q[0].flags));
                void'(tick_q.pop_front());
            end
        end
        if (bus.busy === 1'b1) begin
            brun++;
        end else if (brun != 0) begin
            if (mon_walks) begin
                chk("walk_len", brun, 4);
                if (walk_q.size() == 0) begin
                    chk("walk_unexpected", 1, 0);
                end else begin
                    chk("walk_active", int'(bus.ch_active), int'(walk_q[0]));
                    void'(walk_q.pop_front());
                end
            end
            brun = 0;
        end
    end

    task automatic pulse(input logic [3:0] wr, input logic [3:0] tr,
                         input logic [7:0] d);
        @(posedge clk);
        #1;
        bus.wr_len   = wr;
        bus.trig     = tr;
        bus.len_data = d;
        @(posedge clk);
        #1;
        bus.wr_len = 4'b0000;
        bus.trig   = 4'b0000;
    endtask

    task automatic wait_tick_len();
        bit seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (bus.tick_len) seen = 1'b1;
        end
        if (!seen) chk("tick_len_timeout", 0, 1);
    endtask

    task automatic drain_walks(input int budget);
        int n = 0;
        while (walk_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("walk_q_drained", walk_q.size(), 0);
    endtask

    task automatic drain_ticks(input int budget);
        int n = 0;
        while (tick_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("tick_q_drained", tick_q.size(), 0);
        mon_ticks = 1'b0;
    endtask

    task automatic push_ticks(input int base, input int kmax);
        logic [2:0] st;
        logic [2:0] fl;
        for (int k = 1; k <= kmax; k++) begin
            st = 3'(k % 8);
            fl = {~st[0], st[1:0] == 2'd2, st == 3'd7};
            if (fl != 3'b000)
                tick_q.push_back('{cyc: base + DIV * k + 1,
                                   step: st, flags: fl});
        end
    endtask

    task automatic push_walks(input logic [3:0] a, input int n);
        for (int k = 0; k < n; k++) walk_q.push_back(a);
    endtask

    initial begin
        int base;
        bus.apu_en   = 1'b0;
        bus.wr_len   = 4'b0000;
        bus.trig     = 4'b0000;
        bus.len_data = 8'd0;
        bus.len_en   = 4'b0000;
        bus.dac_on   = 4'b0000;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_step", int'(bus.step), 0);
        chk("rst_ticks",
            int'({bus.tick_len, bus.tick_sweep, bus.tick_env}), 0);
        chk("rst_active", int'(bus.ch_active), 0);
        chk("rst_busy", int'(bus.busy), 0);

        // Tick decode over more than one full frame.
        @(posedge clk);
        #1;
        bus.apu_en = 1'b1;
        base = cyc;
        push_ticks(base, 10);
        mon_ticks = 1'b1;
        while (cyc < base + DIV + 1) @(negedge clk);
        // Step 1 decodes no tick; tick_len first follows the second wrap.
        chk("first_wrap_step", int'(bus.step), 1);
        drain_ticks(400);

        // ch0 length expiry on the S0 edge of the second walk.
        wait_tick_len();
        repeat (6) @(posedge clk);
        #1;
        bus.dac_on[0] = 1'b1;
        bus.len_en[0] = 1'b1;
        pulse(4'b0001, 4'b0000, 8'd62);
        pulse(4'b0000, 4'b0001, 8'd0);
        chk("t3_active_on", int'(bus.ch_active), 1);
        walk_q.push_back(4'b0001);
        walk_q.push_back(4'b0000);
        mon_walks = 1'b1;
        wait_tick_len();
        wait_tick_len();
        @(posedge clk);
        #1 chk("t3_s0_still_on", int'(bus.ch_active[0]), 1);
        @(posedge clk);
        #1 chk("t3_s0_edge_off", int'(bus.ch_active[0]), 0);
        drain_walks(100);

        // Wave channel reloads to 256 and expires after 256 walks.
        bus.dac_on[2] = 1'b1;
        bus.len_en[2] = 1'b1;
        pulse(4'b0000, 4'b0100, 8'd0);
        chk("t4_active_on", int'(bus.ch_active), 4);
        push_walks(4'b0100, 255);
        walk_q.push_back(4'b0000);
        drain_walks(256 * 40);
        bus.len_en[2] = 1'b0;
        pulse(4'b0000, 4'b0100, 8'd0);
        chk("t4_retrig_on", int'(bus.ch_active), 4);
        push_walks(4'b0100, 260);
        drain_walks(260 * 40);

        // Host load in slot S1 wins over the decrement of ch1.
        bus.dac_on = 4'b1111;
        bus.len_en = 4'b1011;
        pulse(4'b0001, 4'b0000, 8'd60);
        pulse(4'b1000, 4'b0000, 8'd61);
        pulse(4'b0010, 4'b0000, 8'd63);
        pulse(4'b0000, 4'b1011, 8'd0);
        chk("t5_active_on", int'(bus.ch_active), 15);
        walk_q.push_back(4'b1111);
        walk_q.push_back(4'b1111);
        walk_q.push_back(4'b0111);
        push_walks(4'b0110, 61);
        walk_q.push_back(4'b0100);
        wait_tick_len();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("t5_busy_in_s1", int'(bus.busy), 1);
        bus.wr_len   = 4'b0010;
        bus.len_data = 8'd0;
        @(posedge clk);
        #1 bus.wr_len = 4'b0000;
        drain_walks(65 * 40);

        // Abort during S2 clears everything; ch0 was left at remaining=1.
        mon_walks = 1'b0;
        bus.len_en[0] = 1'b0;
        pulse(4'b0001, 4'b0000, 8'd63);
        wait_tick_len();
        repeat (3) @(posedge clk);
        #1;
        bus.apu_en = 1'b0;
        chk("t6_busy_s2", int'(bus.busy), 1);
        @(posedge clk);
        #1;
        chk("t6_abort_busy", int'(bus.busy), 0);
        chk("t6_abort_active", int'(bus.ch_active), 0);
        chk("t6_abort_step", int'(bus.step), 0);
        bus.apu_en = 1'b1;
        base = cyc;
        push_ticks(base, 2);
        mon_ticks = 1'b1;
        bus.len_en[0] = 1'b1;
        pulse(4'b0000, 4'b0001, 8'd0);
        bus.len_en[3] = 1'b1;
        pulse(4'b0000, 4'b1000, 8'd0);
        chk("t6_ch3_on", int'(bus.ch_active), 9);
        @(posedge clk);
        #1;
        bus.dac_on[3] = 1'b0;
        bus.trig      = 4'b1000;
        @(posedge clk);
        #1;
        bus.trig = 4'b0000;
        chk("t6_dac_override", int'(bus.ch_active), 1);
        drain_ticks(100);
        repeat (6) @(posedge clk);
        #1 chk("t6_ch0_reloaded", int'(bus.ch_active[0]), 1);

        // Asynchronous reset between edges.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("ar_active", int'(bus.ch_active), 0);
        chk("ar_step", int'(bus.step), 0);
        chk("ar_busy_ticks",
            int'({bus.busy, bus.tick_len, bus.tick_sweep, bus.tick_env}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
